// File: rtl/disp7_pkg.sv
// disp7_pkg: shared constants and hex-to-segment decode for the 7-segment display mux.
package disp7_pkg;
    localparam int SUBTICKS = 16;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction
endpackage

// File: rtl/disp7_hex_decoder.sv
// disp7_hex_decoder: combinational nibble to active-high {g,f,e,d,c,b,a} segment pattern.
module disp7_hex_decoder
    import disp7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = hex_to_seg(hex);
endmodule

// File: rtl/display_mux_7seg_n.sv
// display_mux_7seg_n: N-digit multiplexed 7-segment driver with deadtime, blanking and frame snapshot.
// Defining DISP7_PWM_EN adds per-frame brightness PWM from i_Brillo.
module display_mux_7seg_n
    import disp7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int PRESC_DIV     = 50000,
    parameter int ANODE_ACT_LOW = 1,
    parameter int SEG_ACT_LOW   = 1
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic [4*N_DIGITS-1:0]       i_Datos,
    input  logic [N_DIGITS-1:0]         i_Dp,
    input  logic [N_DIGITS-1:0]         i_Blank,
    input  logic [3:0]                  i_Brillo,
    output logic [N_DIGITS-1:0]         o_Anodos,
    output logic [6:0]                  o_Segmentos,
    output logic                        o_Dp,
    output logic [$clog2(N_DIGITS)-1:0] o_Sel,
    output logic                        o_Frame
);
    localparam int   SW = $clog2(N_DIGITS);
    localparam int   CW = PRESC_DIV > 1 ? $clog2(PRESC_DIV) : 1;
    localparam logic AL = ANODE_ACT_LOW != 0;
    localparam logic SL = SEG_ACT_LOW != 0;

    generate
        if (N_DIGITS < 2 || N_DIGITS > 8 || PRESC_DIV < 1) begin : g_bad_param
            $error("display_mux_7seg_n: N_DIGITS must be 2..8 and PRESC_DIV >= 1");
        end
    endgenerate

    logic [CW-1:0]         cnt;
    logic [3:0]            sub;
    logic [SW-1:0]         sel;
    logic [4*N_DIGITS-1:0] snap_datos;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_blank;
    logic                  tick;
    logic                  slot_end;
    logic                  wrap;
    logic                  lit;
    logic [6:0]            seg_hi;
    logic [N_DIGITS-1:0]   an_hi;

    assign tick     = cnt == CW'(PRESC_DIV - 1);
    assign slot_end = tick && sub == 4'(SUBTICKS - 1);
    assign wrap     = slot_end && sel == SW'(N_DIGITS - 1);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt <= '0;
            sub <= '0;
            sel <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                sub <= sub + 1'b1;
            if (slot_end)
                sel <= wrap ? '0 : sel + 1'b1;
        end
    end

    // Inputs are only ever displayed through these, so a frame never mixes old and new data.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            snap_datos <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
        end else if (wrap) begin
            snap_datos <= i_Datos;
            snap_dp    <= i_Dp;
            snap_blank <= i_Blank;
        end
    end

`ifdef DISP7_PWM_EN
    logic [3:0] snap_bri;
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            snap_bri <= '0;
        else if (wrap)
            snap_bri <= i_Brillo;
    end
    assign lit = sub != 4'd0 && !snap_blank[sel] && sub <= snap_bri;
`else
    logic unused_brillo;
    assign unused_brillo = ^i_Brillo;
    assign lit = sub != 4'd0 && !snap_blank[sel];
`endif

    disp7_hex_decoder u_dec (
        .hex(snap_datos[{sel, 2'b00} +: 4]),
        .seg(seg_hi)
    );

    assign an_hi = lit ? N_DIGITS'(1) << sel : '0;

    // Sub 0 keeps anodes dark while segments settle, which removes ghosting.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Anodos    <= {N_DIGITS{AL}};
            o_Segmentos <= {7{SL}};
            o_Dp        <= SL;
            o_Sel       <= '0;
            o_Frame     <= 1'b0;
        end else begin
            o_Anodos    <= an_hi ^ {N_DIGITS{AL}};
            o_Segmentos <= seg_hi ^ {7{SL}};
            o_Dp        <= snap_dp[sel] ^ SL;
            o_Sel       <= sel;
            o_Frame     <= wrap;
        end
    end
endmodule
